// File: rtl/spi_flash_pkg.sv
// Shared types and constants for the W25Q16BV read sequencer.
// Optional feature macro: SPI_FLASH_FAST_READ_EN (fast-read command with one dummy byte).
package spi_flash_pkg;

  typedef enum logic [3:0] {
    ST_INIT,
    ST_IDLE,
    ST_CMD,
    ST_A2,
    ST_A1,
    ST_A0,
    ST_DUMMY,
    ST_DATA,
    ST_HOLD,
    ST_DESEL,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    X_IDLE,
    X_ISSUE,
    X_WAIT1,
    X_WAIT
  } xfer_state_t;

  localparam logic [7:0]  CMD_READ      = 8'h03;
  localparam logic [7:0]  CMD_FAST_READ = 8'h0B;
  localparam logic [15:0] SPI_DESELECT  = 16'h0100;
  localparam int unsigned SPI_BUSY_BIT  = 15;

endpackage

// File: rtl/spi_flash_reader_xfer.sv
// spi_byte_xfer: one load/wait handshake with the SPI byte engine.
// A go pulse while ready issues one engine word; ack pulses (combinationally)
// in the cycle the byte is complete, with rx_byte valid in that same cycle.
module spi_byte_xfer
  import spi_flash_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        go,
  input  logic [7:0]  tx_byte,
  input  logic        deselect,
  output logic        ready,
  output logic        ack,
  output logic [7:0]  rx_byte,
  output logic        spi_load,
  output logic [15:0] spi_in,
  input  logic [15:0] spi_out
);

  xfer_state_t xstate;
  logic        desel_q;
  logic        spi_out_unused;

  // Handshake sequencer: issue one load, skip the stale busy cycle, then wait for idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      xstate   <= X_IDLE;
      desel_q  <= 1'b0;
      spi_load <= 1'b0;
      spi_in   <= SPI_DESELECT;
    end else begin
      spi_load <= 1'b0;
      case (xstate)
        X_IDLE: begin
          if (go) begin
            spi_load <= 1'b1;
            spi_in   <= deselect ? SPI_DESELECT : {8'h00, tx_byte};
            desel_q  <= deselect;
            xstate   <= X_ISSUE;
          end
        end
        X_ISSUE: xstate <= X_WAIT1;
        // Engine busy lags load by a cycle; a deselect is already complete here.
        X_WAIT1: xstate <= desel_q ? X_IDLE : X_WAIT;
        X_WAIT: begin
          if (!spi_out[SPI_BUSY_BIT]) xstate <= X_IDLE;
        end
        default: xstate <= X_IDLE;
      endcase
    end
  end

  // Completion and readiness decode.
  always_comb begin
    ready   = (xstate == X_IDLE);
    ack     = ((xstate == X_WAIT1) && desel_q) ||
              ((xstate == X_WAIT) && !spi_out[SPI_BUSY_BIT]);
    rx_byte = spi_out[7:0];
  end

  assign spi_out_unused = ^spi_out[14:8];

endmodule

// File: rtl/spi_flash_reader.sv
// spi_flash_reader: issues READ (or FAST_READ) transactions to a W25Q16BV
// through the SPI byte engine and streams received bytes over valid/ready.
// Optional feature macro: SPI_FLASH_FAST_READ_EN (command 0x0B plus one dummy byte).
module spi_flash_reader
  import spi_flash_pkg::*;
#(
  parameter int unsigned CNT_W    = 16,
  parameter logic [7:0]  DUMMY_TX = 8'h00
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [23:0]      addr,
  input  logic [CNT_W-1:0] count,
  output logic             busy,
  output logic             done,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic             spi_load,
  output logic [15:0]      spi_in,
  input  logic [15:0]      spi_out
);

`ifdef SPI_FLASH_FAST_READ_EN
  localparam logic [7:0] CMD_BYTE = CMD_FAST_READ;
`else
  localparam logic [7:0] CMD_BYTE = CMD_READ;
`endif

  state_t           state;
  logic [23:0]      addr_q;
  logic [CNT_W-1:0] remaining;

  logic       x_go;
  logic [7:0] x_tx;
  logic       x_desel;
  logic       x_ready;
  logic       x_ack;
  logic [7:0] x_rx;

  spi_byte_xfer u_xfer (
    .clk      (clk),
    .reset    (reset),
    .go       (x_go),
    .tx_byte  (x_tx),
    .deselect (x_desel),
    .ready    (x_ready),
    .ack      (x_ack),
    .rx_byte  (x_rx),
    .spi_load (spi_load),
    .spi_in   (spi_in),
    .spi_out  (spi_out)
  );

  // Select the engine word for the current state; kick the handshake whenever it is free.
  always_comb begin
    x_tx    = DUMMY_TX;
    x_desel = 1'b0;
    x_go    = 1'b0;
    case (state)
      ST_INIT, ST_DESEL: begin x_desel = 1'b1;        x_go = x_ready; end
      ST_CMD:            begin x_tx = CMD_BYTE;       x_go = x_ready; end
      ST_A2:             begin x_tx = addr_q[23:16];  x_go = x_ready; end
      ST_A1:             begin x_tx = addr_q[15:8];   x_go = x_ready; end
      ST_A0:             begin x_tx = addr_q[7:0];    x_go = x_ready; end
      ST_DUMMY:          begin x_tx = 8'h00;          x_go = x_ready; end
      ST_DATA:           begin x_tx = DUMMY_TX;       x_go = x_ready; end
      default: ;
    endcase
  end

  // Transaction sequencer with registered status and stream outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_INIT;
      busy      <= 1'b1;
      done      <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      addr_q    <= '0;
      remaining <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_INIT: begin
          if (x_ack) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        ST_IDLE: begin
          if (start) begin
            if (count == '0) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              addr_q    <= addr;
              remaining <= count;
              busy      <= 1'b1;
              state     <= ST_CMD;
            end
          end
        end
        ST_CMD: if (x_ack) state <= ST_A2;
        ST_A2:  if (x_ack) state <= ST_A1;
        ST_A1:  if (x_ack) state <= ST_A0;
        ST_A0: begin
`ifdef SPI_FLASH_FAST_READ_EN
          if (x_ack) state <= ST_DUMMY;
`else
          if (x_ack) state <= ST_DATA;
`endif
        end
        ST_DUMMY: if (x_ack) state <= ST_DATA;
        ST_DATA: begin
          if (x_ack) begin
            rd_data  <= x_rx;
            rd_valid <= 1'b1;
            state    <= ST_HOLD;
          end
        end
        // rd_valid rose on entry here, so a same-cycle rd_ready is only seen next edge.
        ST_HOLD: begin
          if (rd_valid && rd_ready) begin
            rd_valid  <= 1'b0;
            remaining <= remaining - CNT_W'(1);
            state     <= (remaining == CNT_W'(1)) ? ST_DESEL : ST_DATA;
          end
        end
        // done is raised on entry to DONE so it and the busy drop share one cycle.
        ST_DESEL: begin
          if (x_ack) begin
            state <= ST_DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_flash_reader.sv
// Self-checking bench for spi_flash_reader with a cycle-level SPI engine/flash model.
// Honors SPI_FLASH_FAST_READ_EN when defined for the build.
module tb_spi_flash_reader;

  localparam int unsigned CNT_W = 16;
  localparam int unsigned BT    = 4;   // engine busy cycles per byte
`ifdef SPI_FLASH_FAST_READ_EN
  localparam int unsigned HDR     = 5;
  localparam int unsigned EXP_LAT = 49;
  localparam logic [7:0]  CMD_B   = 8'h0B;
`else
  localparam int unsigned HDR     = 4;
  localparam int unsigned EXP_LAT = 41;
  localparam logic [7:0]  CMD_B   = 8'h03;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             start = 1'b0;
  logic [23:0]      addr = '0;
  logic [CNT_W-1:0] count = '0;
  logic             rd_ready = 1'b0;
  logic             busy, done, rd_valid, spi_load;
  logic [7:0]       rd_data;
  logic [15:0]      spi_in, spi_out;

  spi_flash_reader #(.CNT_W(CNT_W), .DUMMY_TX(8'h00)) dut (
    .clk(clk), .reset(reset), .start(start), .addr(addr), .count(count),
    .busy(busy), .done(done), .rd_data(rd_data), .rd_valid(rd_valid),
    .rd_ready(rd_ready), .spi_load(spi_load), .spi_in(spi_in), .spi_out(spi_out)
  );

  always #5 clk = ~clk;

  // ---------------- engine + flash model ----------------
  logic [7:0]  data_tbl [0:3];
  logic        pend = 1'b0;
  int unsigned cnt = 0;
  int unsigned idx = 0;
  logic [7:0]  rx = 8'h00;
  logic [7:0]  next_rx = 8'h00;

  initial begin
    data_tbl[0] = 8'hA5; data_tbl[1] = 8'h3C; data_tbl[2] = 8'h77; data_tbl[3] = 8'hC8;
  end

  // Busy appears one cycle after the load is seen, lasts BT cycles, rx updates as it clears.
  always @(posedge clk) begin
    if (spi_load) begin
      if (spi_in[8]) begin
        pend <= 1'b0; cnt <= 0; idx <= 0;
      end else begin
        pend    <= 1'b1;
        idx     <= idx + 1;
        next_rx <= (idx >= HDR) ? data_tbl[(idx - HDR) % 4] : 8'hFF;
      end
    end else if (pend) begin
      pend <= 1'b0; cnt <= BT;
    end else if (cnt != 0) begin
      cnt <= cnt - 1;
      if (cnt == 1) rx <= next_rx;
    end
  end
  assign spi_out = {(cnt != 0), 7'h00, rx};

  // ---------------- scoreboard ----------------
  int unsigned n_checks = 0, n_pass = 0;
  int unsigned n_loads = 0, n_done = 0;
  logic [15:0] exp_words[$];
  logic [7:0]  exp_rx[$];
  logic [15:0] log_words[$];

  function automatic void check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h want %0h", name, got, want);
  endfunction

  // Expected engine words and stream bytes for one READ transaction.
  task automatic plan(input logic [23:0] a, input int unsigned n);
    exp_words.push_back({8'h00, CMD_B});
    exp_words.push_back({8'h00, a[23:16]});
    exp_words.push_back({8'h00, a[15:8]});
    exp_words.push_back({8'h00, a[7:0]});
`ifdef SPI_FLASH_FAST_READ_EN
    exp_words.push_back(16'h0000);
`endif
    for (int i = 0; i < int'(n); i++) begin
      exp_words.push_back(16'h0000);
      exp_rx.push_back(data_tbl[i % 4]);
    end
    exp_words.push_back(16'h0100);
  endtask

  // Compare process: every cycle out of reset.
  initial begin
    logic prev_hold;
    logic prev_done;
    logic [7:0] prev_data;
    prev_hold = 1'b0; prev_done = 1'b0; prev_data = 8'h00;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_hold = 1'b0; prev_done = 1'b0;
      end else begin
        if (spi_load) begin
          n_loads++;
          log_words.push_back(spi_in);
          if (exp_words.size() == 0) check("spurious_load", {16'h0, spi_in}, 32'hFFFF_FFFF);
          else check("load_word", {16'h0, spi_in}, {16'h0, exp_words.pop_front()});
          check("load_while_valid", {31'h0, rd_valid}, 32'h0);
        end
        if (prev_hold) begin
          check("hold_valid", {31'h0, rd_valid}, 32'h1);
          check("hold_data", {24'h0, rd_data}, {24'h0, prev_data});
        end
        if (rd_valid && rd_ready) begin
          if (exp_rx.size() == 0) check("spurious_rd", {24'h0, rd_data}, 32'hFFFF_FFFF);
          else check("rd_data", {24'h0, rd_data}, {24'h0, exp_rx.pop_front()});
        end
        if (done) begin
          n_done++;
          check("done_busy", {31'h0, busy}, 32'h0);
          check("done_single", {31'h0, prev_done}, 32'h0);
        end
        prev_hold = rd_valid && !rd_ready;
        prev_data = rd_data;
        prev_done = done;
      end
    end
  end

  // ---------------- directed tasks ----------------
  task automatic do_start(input logic [23:0] a, input logic [CNT_W-1:0] n);
    @(posedge clk); #1;
    addr = a; count = n; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int unsigned limit);
    int unsigned d0;
    int unsigned k;
    d0 = n_done; k = 0;
    while (n_done == d0 && k < limit) begin @(posedge clk); #1; k++; end
    check("done_seen", {31'h0, (n_done != d0)}, 32'h1);
  endtask

  task automatic wait_idle(input int unsigned limit);
    int unsigned k;
    k = 0;
    while (busy && k < limit) begin @(posedge clk); #1; k++; end
    check("idle_seen", {31'h0, busy}, 32'h0);
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_busy"},     {31'h0, busy},     32'h1);
    check({tag, "_done"},     {31'h0, done},     32'h0);
    check({tag, "_rd_valid"}, {31'h0, rd_valid}, 32'h0);
    check({tag, "_rd_data"},  {24'h0, rd_data},  32'h0);
    check({tag, "_spi_load"}, {31'h0, spi_load}, 32'h0);
    check({tag, "_spi_in"},   {16'h0, spi_in},   32'h0100);
  endtask

  task automatic check_log(input int unsigned base, input logic [15:0] lit[$]);
    check("log_len", log_words.size() - base, lit.size());
    for (int i = 0; i < lit.size() && base + i < log_words.size(); i++)
      check("log_word", {16'h0, log_words[base + i]}, {16'h0, lit[i]});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned base, loads0, lat, d0;
    logic [15:0] lit[$];

    // Reset and the INIT deselect.
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outs("rst");
    exp_words.push_back(16'h0100);
    reset = 1'b0;
    wait_idle(20);
    check("init_loads", n_loads, 1);
    repeat (5) @(posedge clk);
    #1;
    check("init_quiet", n_loads, 1);

    // Two-byte read, consumer always ready; also pins first-byte latency.
    base = log_words.size();
    plan(24'h012345, 2);
    rd_ready = 1'b1;
    do_start(24'h012345, 2);
    lat = 1;
    while (!rd_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    check("first_byte_latency", lat, EXP_LAT);
    check("first_byte", {24'h0, rd_data}, 32'hA5);
    wait_done(200);
    #1;
    check("t2_busy", {31'h0, busy}, 32'h0);
`ifdef SPI_FLASH_FAST_READ_EN
    lit = '{16'h000B, 16'h0001, 16'h0023, 16'h0045, 16'h0000, 16'h0000, 16'h0000, 16'h0100};
`else
    lit = '{16'h0003, 16'h0001, 16'h0023, 16'h0045, 16'h0000, 16'h0000, 16'h0100};
`endif
    check_log(base, lit);
    check("t2_words_left", exp_words.size(), 0);
    check("t2_rx_left", exp_rx.size(), 0);

    // Backpressure: stall 50 cycles after the first byte.
    plan(24'h012345, 2);
    rd_ready = 1'b0;
    do_start(24'h012345, 2);
    lat = 0;
    while (!rd_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    loads0 = n_loads;
    for (int i = 0; i < 50; i++) begin
      check("stall_valid", {31'h0, rd_valid}, 32'h1);
      check("stall_data", {24'h0, rd_data}, 32'hA5);
      @(posedge clk); #1;
    end
    check("stall_no_load", n_loads, loads0);
    rd_ready = 1'b1;
    wait_done(200);
    check("t3_words_left", exp_words.size(), 0);
    check("t3_rx_left", exp_rx.size(), 0);

    // Zero-length request: done quickly, no SPI traffic.
    repeat (2) @(posedge clk);
    loads0 = n_loads; d0 = n_done;
    do_start(24'h000100, 0);
    lat = 1;
    while (!done && lat < 10) begin @(posedge clk); #1; lat++; end
    check("zero_done_lat", {31'h0, (lat <= 2)}, 32'h1);
    repeat (5) @(posedge clk);
    #1;
    check("zero_no_load", n_loads, loads0);
    check("zero_one_done", n_done, d0 + 1);

    // Reset during the A1 byte, then recovery.
    plan(24'h012345, 1);
    loads0 = n_loads;
    do_start(24'h012345, 1);
    lat = 0;
    while (n_loads < loads0 + 3 && lat < 200) begin @(posedge clk); #1; lat++; end
    check("reached_a1", n_loads, loads0 + 3);
    reset = 1'b1;
    #1;
    check_reset_outs("midrst");
    exp_words.delete();
    exp_rx.delete();
    exp_words.push_back(16'h0100);
    repeat (2) @(posedge clk);
    #1;
    loads0 = n_loads;
    reset = 1'b0;
    wait_idle(20);
    check("midrst_desel_loads", n_loads, loads0 + 1);

    // Single byte from address 0 after recovery.
    base = log_words.size();
    plan(24'h000000, 1);
    do_start(24'h000000, 1);
    wait_done(200);
`ifdef SPI_FLASH_FAST_READ_EN
    lit = '{16'h000B, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0100};
`else
    lit = '{16'h0003, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0100};
`endif
    check_log(base, lit);
    check("t6_words_left", exp_words.size(), 0);
    check("t6_rx_left", exp_rx.size(), 0);
    check("t6_busy", {31'h0, busy}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
